// File: rtl/secuenciador_spi.sv
// Sequencer that streams bytes into an SPI controller's RAM, arms a transfer, waits for completion
// with a watchdog, then reads the received bytes back out. Bus outputs lag the causing state by one cycle.
module secuenciador_spi #(
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [8:0]  n_bytes_i,
   input  logic [1:0]  fill_i,
   input  logic [7:0]  tx_byte_i,
   input  logic        tx_valid_i,
   output logic        tx_ready_o,
   output logic        reg_sel_o,
   output logic        wr_o,
   output logic [31:0] entrada_o,
   output logic [31:0] addr_o,
   input  logic [31:0] bits_i,
   input  logic        tx_done_i,
   output logic [7:0]  rx_byte_o,
   output logic        rx_valid_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o
);

   localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_ARM, S_WAIT, S_CLR, S_RADDR, S_RCAP, S_FIN
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    rst_sync_q;
   logic          run;
   logic [8:0]    k_q, k_d, cnt_q, cnt_d;
   logic [1:0]    fill_q, fill_d;
   logic [WW-1:0] wdog_q, wdog_d;
   logic          reg_sel_q, reg_sel_d, wr_q, wr_d;
   logic [31:0]   entrada_q, entrada_d, addr_q, addr_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   logic          rx_valid_q, rx_valid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic          unused_bits;

   assign unused_bits = ^bits_i[31:8];

   // Reset asserts asynchronously but is released through two flops, so no transition races the release.
   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign run = rst_sync_q[1];

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      cnt_d      = cnt_q;
      fill_d     = fill_q;
      wdog_d     = wdog_q;
      reg_sel_d  = 1'b0;
      wr_d       = 1'b0;
      entrada_d  = entrada_q;
      addr_d     = addr_q;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = 1'b0;
      done_d     = 1'b0;
      err_d      = err_q;
      if (run) begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  if ((n_bytes_i != 9'd0) && (n_bytes_i <= 9'd256)) begin
                     cnt_d   = n_bytes_i;
                     fill_d  = fill_i;
                     err_d   = 1'b0;
                     k_d     = 9'd0;
                     state_d = S_LOAD;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (tx_valid_i) begin
                  reg_sel_d = 1'b1;
                  wr_d      = 1'b1;
                  addr_d    = {24'h0, k_q[7:0]};
                  entrada_d = {24'h0, tx_byte_i};
                  if (k_q == cnt_q - 9'd1) state_d = S_ARM;
                  else                     k_d = k_q + 9'd1;
               end
            end
            S_ARM: begin
               wr_d      = 1'b1;
               entrada_d = {19'h0, cnt_q, fill_q[1], fill_q[0], 1'b0, 1'b1};
               wdog_d    = '0;
               state_d   = S_WAIT;
            end
            S_WAIT, S_CLR: begin
               // The watchdog spans both the completion wait and the status poll.
               if (wdog_q == WD_LAST) begin
                  err_d   = 1'b1;
                  state_d = S_FIN;
               end else begin
                  wdog_d = wdog_q + WW'(1);
                  if (state_q == S_WAIT) begin
                     if (tx_done_i) state_d = S_CLR;
                  end else if (!bits_i[0]) begin
                     k_d     = 9'd0;
                     state_d = S_RADDR;
                  end
               end
            end
            S_RADDR: begin
               reg_sel_d = 1'b1;
               addr_d    = {24'h0, k_q[7:0]};
               state_d   = S_RCAP;
            end
            S_RCAP: begin
               rx_byte_d  = bits_i[7:0];
               rx_valid_d = 1'b1;
               if (k_q == cnt_q - 9'd1) begin
                  state_d = S_FIN;
               end else begin
                  k_d     = k_q + 9'd1;
                  state_d = S_RADDR;
               end
            end
            S_FIN: begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= S_IDLE;
         k_q        <= '0;
         cnt_q      <= '0;
         fill_q     <= '0;
         wdog_q     <= '0;
         reg_sel_q  <= 1'b0;
         wr_q       <= 1'b0;
         entrada_q  <= '0;
         addr_q     <= '0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         cnt_q      <= cnt_d;
         fill_q     <= fill_d;
         wdog_q     <= wdog_d;
         reg_sel_q  <= reg_sel_d;
         wr_q       <= wr_d;
         entrada_q  <= entrada_d;
         addr_q     <= addr_d;
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign tx_ready_o = (state_q == S_LOAD);
   assign reg_sel_o  = reg_sel_q;
   assign wr_o       = wr_q;
   assign entrada_o  = entrada_q;
   assign addr_o     = addr_q;
   assign rx_byte_o  = rx_byte_q;
   assign rx_valid_o = rx_valid_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_secuenciador_spi.sv
// Bench for secuenciador_spi: table of transactions against a small controller model, plus boundary,
// timeout and reset-in-WAIT sequences.
module tb_secuenciador_spi;

   logic        clk, rst_i, start_i, tx_valid_i, tx_ready_o, reg_sel_o, wr_o;
   logic [8:0]  n_bytes_i;
   logic [1:0]  fill_i;
   logic [7:0]  tx_byte_i, rx_byte_o;
   logic [31:0] entrada_o, addr_o, bits_i;
   logic        tx_done_i, rx_valid_o, busy_o, done_o, err_o;

   secuenciador_spi #(.TIMEOUT_CYC(100)) dut (
      .clk(clk), .rst_i(rst_i), .start_i(start_i), .n_bytes_i(n_bytes_i), .fill_i(fill_i),
      .tx_byte_i(tx_byte_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
      .reg_sel_o(reg_sel_o), .wr_o(wr_o), .entrada_o(entrada_o), .addr_o(addr_o),
      .bits_i(bits_i), .tx_done_i(tx_done_i), .rx_byte_o(rx_byte_o), .rx_valid_o(rx_valid_o),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Controller model: RAM written by data writes, status bit 0 busy until tx_done.
   logic [7:0]  ram [256];
   logic        status_busy;
   assign bits_i = reg_sel_o ? {24'h0, ram[addr_o[7:0]]} : {31'h0, status_busy};

   logic [63:0] wq [$];
   logic [7:0]  rxq [$];
   logic [31:0] ctrl_word;
   int cyc = 0, ctrl_cnt = 0, ctrl_cyc = 0, done_cnt = 0, done_cyc = 0, err_cyc = 0, busy_cnt = 0;
   logic err_prev = 1'b0;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (wr_o) begin
         if (reg_sel_o) begin
            wq.push_back({addr_o, entrada_o});
            ram[addr_o[7:0]] = entrada_o[7:0];
         end else begin
            ctrl_word = entrada_o;
            ctrl_cnt  = ctrl_cnt + 1;
            ctrl_cyc  = cyc;
         end
      end
      if (rx_valid_o) rxq.push_back(rx_byte_o);
      if (done_o) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (busy_o) busy_cnt = busy_cnt + 1;
      if (err_o && !err_prev) err_cyc = cyc;
      err_prev = err_o;
   end

   int n_chk = 0, n_fail = 0;
   int wb, rb, db, cb, bb;
   logic [7:0] tx_bytes [256];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_txn(input logic [8:0] n, input logic [1:0] fill, input int delay, input bit toggle);
      int j, guard;
      logic hs;
      wb = wq.size(); rb = rxq.size(); db = done_cnt; cb = ctrl_cnt; bb = busy_cnt;
      @(negedge clk); start_i = 1'b1; n_bytes_i = n; fill_i = fill;
      @(negedge clk); start_i = 1'b0;
      if (n == 9'd0 || n > 9'd256) begin
         repeat (4) @(negedge clk);
         return;
      end
      j = 0; guard = 0;
      while (j < int'(n) && guard < 4000) begin
         if (toggle && (guard % 2 == 1)) tx_valid_i = 1'b0;
         else begin
            tx_valid_i = 1'b1;
            tx_byte_i  = tx_bytes[j];
         end
         hs = tx_valid_i && tx_ready_o;
         @(negedge clk);
         if (hs) j++;
         guard++;
      end
      tx_valid_i = 1'b0;
      chk("load_count", 64'(j), 64'(n));
      guard = 0;
      while (ctrl_cnt == cb && guard < 20) begin @(negedge clk); guard++; end
      status_busy = 1'b1;
      if (delay >= 0) begin
         repeat (delay) @(negedge clk);
         tx_done_i = 1'b1; status_busy = 1'b0;
         @(negedge clk);
         tx_done_i = 1'b0;
      end
      guard = 0;
      while (done_cnt == db && guard < 1200) begin @(negedge clk); guard++; end
      chk("done_seen", 64'(done_cnt - db), 64'd1);
      @(negedge clk);
   endtask

   typedef struct {
      logic [8:0]  n;
      logic [1:0]  fill;
      logic        exp_err;
      logic [31:0] exp_ctrl;
   } vec_t;

   vec_t vecs [6];
   logic [7:0] basic_bytes [3];
   int mism, last_addr;

   initial begin
      vecs[0] = '{9'd3,   2'd0, 1'b0, 32'h0000_0031};
      vecs[1] = '{9'd0,   2'd0, 1'b1, 32'h0};
      vecs[2] = '{9'd1,   2'd1, 1'b0, 32'h0000_0015};
      vecs[3] = '{9'd257, 2'd0, 1'b1, 32'h0};
      vecs[4] = '{9'd2,   2'd2, 1'b0, 32'h0000_0029};
      vecs[5] = '{9'd5,   2'd3, 1'b0, 32'h0000_005D};
      basic_bytes = '{8'hA5, 8'h3C, 8'hFF};

      rst_i = 1'b1; start_i = 1'b0; n_bytes_i = '0; fill_i = '0; tx_byte_i = '0;
      tx_valid_i = 1'b0; tx_done_i = 1'b0; status_busy = 1'b0;
      #3 rst_i = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ctl", 64'({busy_o, done_o, err_o, wr_o, reg_sel_o, tx_ready_o, rx_valid_o}), 64'd0);
      chk("rst_bus", {addr_o, entrada_o}, 64'd0);
      chk("rst_rx", 64'(rx_byte_o), 64'd0);
      rst_i = 1'b1;
      repeat (3) @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         for (int j = 0; j < 8; j++)
            tx_bytes[j] = (v == 0 && j < 3) ? basic_bytes[j] : 8'(j * 37 + v * 11 + 1);
         run_txn(vecs[v].n, vecs[v].fill, 40, 1'b0);
         chk($sformatf("v%0d_err", v), 64'(err_o), 64'(vecs[v].exp_err));
         chk($sformatf("v%0d_busy_after", v), 64'(busy_o), 64'd0);
         if (vecs[v].exp_err) begin
            chk($sformatf("v%0d_no_busy", v), 64'(busy_cnt - bb), 64'd0);
            chk($sformatf("v%0d_no_writes", v), 64'(wq.size() - wb), 64'd0);
         end else begin
            chk($sformatf("v%0d_nwrites", v), 64'(wq.size() - wb), 64'(vecs[v].n));
            for (int j = 0; j < int'(vecs[v].n); j++)
               if (wb + j < wq.size())
                  chk($sformatf("v%0d_wr%0d", v, j), wq[wb + j], {32'(j), 24'h0, tx_bytes[j]});
            chk($sformatf("v%0d_nctrl", v), 64'(ctrl_cnt - cb), 64'd1);
            chk($sformatf("v%0d_ctrl", v), 64'(ctrl_word), 64'(vecs[v].exp_ctrl));
            chk($sformatf("v%0d_nrx", v), 64'(rxq.size() - rb), 64'(vecs[v].n));
            for (int j = 0; j < int'(vecs[v].n); j++)
               if (rb + j < rxq.size())
                  chk($sformatf("v%0d_rx%0d", v, j), 64'(rxq[rb + j]), 64'(tx_bytes[j]));
         end
      end

      // 256-byte boundary with a gappy tx_valid stream.
      for (int j = 0; j < 256; j++) tx_bytes[j] = 8'(j) ^ 8'h5A;
      run_txn(9'd256, 2'd0, 5, 1'b1);
      chk("b256_nwrites", 64'(wq.size() - wb), 64'd256);
      last_addr = 0; mism = 0;
      for (int j = wb; j < wq.size(); j++)
         if (int'(wq[j][63:32]) > last_addr) last_addr = int'(wq[j][63:32]);
      chk("b256_max_addr", 64'(last_addr), 64'd255);
      chk("b256_ctrl", 64'(ctrl_word), 64'h1001);
      chk("b256_nrx", 64'(rxq.size() - rb), 64'd256);
      for (int j = 0; j < 256; j++)
         if (rb + j >= rxq.size() || rxq[rb + j] !== tx_bytes[j]) mism++;
      chk("b256_rx_mismatches", 64'(mism), 64'd0);
      chk("b256_err", 64'(err_o), 64'd0);

      // Timeout: tx_done never comes.
      for (int j = 0; j < 4; j++) tx_bytes[j] = 8'(8'hC0 + j);
      run_txn(9'd4, 2'd1, -1, 1'b0);
      chk("to_err", 64'(err_o), 64'd1);
      chk("to_err_cycle", 64'(err_cyc - ctrl_cyc), 64'd100);
      chk("to_done_cycle", 64'(done_cyc - ctrl_cyc), 64'd101);
      chk("to_nrx", 64'(rxq.size() - rb), 64'd0);
      chk("to_idle", 64'({busy_o, tx_ready_o}), 64'd0);
      status_busy = 1'b0;

      // Reset during WAIT, with an ignored start while busy.
      tx_bytes[0] = 8'h11; tx_bytes[1] = 8'h22;
      @(negedge clk); start_i = 1'b1; n_bytes_i = 9'd2; fill_i = 2'd0;
      @(negedge clk); start_i = 1'b0; tx_valid_i = 1'b1; tx_byte_i = tx_bytes[0];
      @(negedge clk); tx_byte_i = tx_bytes[1];
      @(negedge clk); tx_valid_i = 1'b0;
      repeat (6) @(negedge clk);
      start_i = 1'b1; n_bytes_i = 9'd0;
      @(negedge clk); start_i = 1'b0;
      @(negedge clk);
      chk("busy_start_err", 64'(err_o), 64'd0);
      chk("busy_in_wait", 64'(busy_o), 64'd1);
      rst_i = 1'b0;
      #1;
      chk("rstw_ctl", 64'({busy_o, done_o, err_o, wr_o, reg_sel_o, tx_ready_o, rx_valid_o}), 64'd0);
      chk("rstw_bus", {addr_o, entrada_o}, 64'd0);
      @(negedge clk); rst_i = 1'b1;
      repeat (3) @(negedge clk);
      run_txn(9'd2, 2'd1, 3, 1'b0);
      chk("post_rst_err", 64'(err_o), 64'd0);
      chk("post_rst_ctrl", 64'(ctrl_word), 64'h0000_0025);
      chk("post_rst_nrx", 64'(rxq.size() - rb), 64'd2);
      if (rb + 1 < rxq.size()) chk("post_rst_rx", 64'({rxq[rb], rxq[rb + 1]}), 64'h1122);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/secuenciador_spi.md
SECUENCIADOR_SPI -- requirements
Module: secuenciador_spi

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50000: clock cycles to wait for tx_done_i before declaring a timeout.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  reset, asynchronous assertion, active-low.
REQ-004 start_i  input  1  one-cycle request to begin a transaction; sampled only in IDLE.
REQ-005 n_bytes_i  input  9  byte count, captured at start; legal range 1..256.
REQ-006 fill_i  input  2  fill mode, captured at start: bit0 maps to all_1s, bit1 maps to all_0s.
REQ-007 tx_byte_i / tx_valid_i / tx_ready_o  in/in/out  8/1/1  transmit byte stream; a byte transfers when tx_valid_i and tx_ready_o are both high.
REQ-008 reg_sel_o, wr_o  output  1, 1  controller bus select and write strobe.
REQ-009 entrada_o, addr_o  output  32, 32  controller bus write data and RAM address.
REQ-010 bits_i  input  32  controller read-data bus.
REQ-011 tx_done_i  input  1  controller transmission-complete flag.
REQ-012 rx_byte_o / rx_valid_o  output  8/1  received-byte stream, one byte per valid pulse, no backpressure.
REQ-013 busy_o, done_o, err_o  output  1 each  busy level; one-cycle completion pulse; sticky error flag cleared by the next accepted start.

Function
REQ-014 States: IDLE, LOAD, ARM, WAIT, CLR, RADDR, RCAP, FIN.
REQ-015 IDLE: start_i=1 with 1<=n_bytes_i<=256 -> capture count and fill mode, clear err_o, index k=0, go to LOAD; any other count -> err_o=1, stay IDLE.
REQ-016 LOAD: tx_ready_o=1; each handshake drives reg_sel_o=1, wr_o=1, addr_o=k, entrada_o={24'h0,tx_byte_i} in that same cycle, then k++.
REQ-017 LOAD: after the handshake with k=count-1, go to ARM; no time limit applies while waiting for tx_valid_i.
REQ-018 ARM (one cycle): reg_sel_o=0, wr_o=1, entrada_o[0]=1, [2]=fill bit0, [3]=fill bit1, [12:4]=count, all other bits 0; go to WAIT.
REQ-019 WAIT: bus idle (wr_o=0, reg_sel_o=0); tx_done_i=1 -> CLR.
REQ-020 WAIT: watchdog counts cycles in WAIT; reaching TIMEOUT_CYC -> err_o=1, go to FIN.
REQ-021 CLR: reg_sel_o=0, wr_o=0; bits_i[0]=0 -> k=0, go to RADDR; the WAIT watchdog continues and applies here too.
REQ-022 RADDR: reg_sel_o=1, wr_o=0, addr_o=k; go to RCAP next cycle.
REQ-023 RCAP: hold addr_o; rx_byte_o=bits_i[7:0], rx_valid_o=1 for one cycle; k++.
REQ-024 RCAP: if k was count-1 go to FIN, else go to RADDR (read throughput: 2 cycles per byte).
REQ-025 FIN: done_o=1 for one cycle, go to IDLE.
REQ-026 busy_o=1 in every state except IDLE.
REQ-027 Outside LOAD and ARM, wr_o=0.
REQ-028 All outputs are registered except tx_ready_o; no output glitches on wr_o.
REQ-029 addr_o[31:8]=0 always; k is 9 bits wide, so count=256 ends at k=255 with no wrap.
REQ-030 start_i while busy_o=1 is ignored; err_o is unchanged.
REQ-031 tx_done_i already high on entry to WAIT moves to CLR on the next cycle.

Reset
REQ-032 rst_i=0 forces IDLE immediately, in any state including mid-LOAD and mid-WAIT.
REQ-033 Reset values: all outputs 0, k=0, watchdog=0, captured count and fill mode = 0.
REQ-034 Release of rst_i is synchronised to clk; first state transition is no earlier than the second rising edge after release.

Verification
REQ-035 Basic transaction: n_bytes=3, bytes A5,3C,FF, fill=0 -> three RAM writes at addr 0,1,2.
REQ-036 Basic transaction (cont.): control write entrada_o=32'h0000_0031; tx_done after 40 cycles; bits_i[0]=0.
REQ-037 Basic transaction (cont.): three rx_valid pulses carry the model RAM contents; then done_o pulse; busy_o low.
REQ-038 Boundary: n_bytes=256, tx_valid toggling every other cycle -> addr_o reaches 255, entrada_o[12:4]=9'h100, exactly 256 rx_valid pulses.
REQ-039 Errors: n_bytes=0 -> err_o=1, busy_o stays 0; n_bytes=257 -> same.
REQ-040 Timeout: TIMEOUT_CYC=100, tx_done_i never asserted -> err_o=1 and done_o pulse at cycle 100 of WAIT, then IDLE.
REQ-041 Reset in WAIT: rst_i low -> all outputs 0 immediately; next start completes normally with err_o=0.
